// File: rtl/bullet_render_sweeper_pkg.sv
// Shared screen geometry, colours and sweep FSM encoding for the bullet renderer.
package bullet_render_sweeper_pkg;
  localparam int SCREEN_MAX_X = 159;
  localparam int SCREEN_MAX_Y = 119;
  localparam int COORD_X_W    = 8;
  localparam int COORD_Y_W    = 7;
  localparam int COLOUR_W     = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_FG = 3'b111;
  localparam logic [COLOUR_W-1:0] COLOUR_BG = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ERASE,
    S_DRAW,
    S_UPDATE,
    S_DONE
  } sweep_state_e;
endpackage

// File: rtl/bullet_shadow_ram.sv
// Per-slot record of the pixel last drawn: combinational read, synchronous write,
// and a reset that only clears the valid bits (coordinates are don't-care when invalid).
module bullet_shadow_ram
  import bullet_render_sweeper_pkg::*;
#(
  parameter int NUM_SLOTS = 160,
  parameter int IDX_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     i_addr,
  input  logic                 i_we,
  input  logic [COORD_X_W-1:0] i_x,
  input  logic [COORD_Y_W-1:0] i_y,
  input  logic                 i_v,
  output logic [COORD_X_W-1:0] o_x,
  output logic [COORD_Y_W-1:0] o_y,
  output logic                 o_v
);
  logic [COORD_X_W+COORD_Y_W-1:0] r_pos [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]           r_valid;

  always_ff @(posedge clk) begin
    if (i_we) r_pos[i_addr] <= {i_x, i_y};
  end

  always_ff @(posedge clk) begin
    if (reset)     r_valid         <= '0;
    else if (i_we) r_valid[i_addr] <= i_v;
  end

  assign {o_x, o_y} = r_pos[i_addr];
  assign o_v        = r_valid[i_addr];
endmodule

// File: rtl/bullet_render_sweeper.sv
// Frame-tick driven sweep over the bullet pool: per slot, erase the previously
// drawn pixel and plot the current one, skipping both when the bullet has not moved.
module bullet_render_sweeper
  import bullet_render_sweeper_pkg::*;
#(
  parameter int         NUM_SLOTS = 160,
  parameter int         IDX_W     = 8,
  parameter int         MAX_X     = SCREEN_MAX_X,
  parameter int         MAX_Y     = SCREEN_MAX_Y,
  parameter logic [2:0] FG_COLOUR = COLOUR_FG,
  parameter logic [2:0] BG_COLOUR = COLOUR_BG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  output logic [IDX_W-1:0] slot_idx,
  input  logic [7:0]       slot_x,
  input  logic [6:0]       slot_y,
  input  logic             slot_active,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  input  logic             vga_ready,
  output logic             busy,
  output logic             sweep_done,
  output logic             overrun
);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [COORD_X_W-1:0] LIM_X    = COORD_X_W'(MAX_X);
  localparam logic [COORD_Y_W-1:0] LIM_Y    = COORD_Y_W'(MAX_Y);

  sweep_state_e         r_state;
  logic [IDX_W-1:0]     r_slot_idx;
  logic [COORD_X_W-1:0] r_cur_x;
  logic [COORD_Y_W-1:0] r_cur_y;
  logic                 r_cur_v;
  logic                 r_need_draw;
  logic [COORD_X_W-1:0] r_vga_x;
  logic [COORD_Y_W-1:0] r_vga_y;
  logic [COLOUR_W-1:0]  r_vga_col;
  logic                 r_vga_plot;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pending;
  logic                 r_overrun;

  logic [COORD_X_W-1:0] w_prev_x;
  logic [COORD_Y_W-1:0] w_prev_y;
  logic                 w_prev_v;
  logic                 w_drawable;
  logic                 w_same;
  logic                 w_shadow_we;

  assign w_shadow_we = (r_state == S_UPDATE);

  bullet_shadow_ram #(
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .i_addr(r_slot_idx),
    .i_we  (w_shadow_we),
    .i_x   (r_cur_x),
    .i_y   (r_cur_y),
    .i_v   (r_cur_v),
    .o_x   (w_prev_x),
    .o_y   (w_prev_y),
    .o_v   (w_prev_v)
  );

  // Only meaningful in LATCH, when the pool data for r_slot_idx has arrived.
  assign w_drawable = slot_active && (slot_x <= LIM_X) && (slot_y <= LIM_Y);
  assign w_same     = w_prev_v && w_drawable && (w_prev_x == slot_x) && (w_prev_y == slot_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_slot_idx  <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_cur_v     <= 1'b0;
      r_need_draw <= 1'b0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_col   <= '0;
      r_vga_plot  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // One tick may queue behind a running sweep; a second one is dropped and flagged.
      if (r_state != S_IDLE && frame_tick) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_tick || r_pending) begin
            r_slot_idx <= '0;
            r_pending  <= r_pending & frame_tick;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_cur_x     <= slot_x;
          r_cur_y     <= slot_y;
          r_cur_v     <= w_drawable;
          r_need_draw <= w_drawable && !w_same;
          if (w_prev_v && !w_same) begin
            r_vga_x    <= w_prev_x;
            r_vga_y    <= w_prev_y;
            r_vga_col  <= BG_COLOUR;
            r_vga_plot <= 1'b1;
            r_state    <= S_ERASE;
          end else if (w_drawable && !w_same) begin
            r_vga_x    <= slot_x;
            r_vga_y    <= slot_y;
            r_vga_col  <= FG_COLOUR;
            r_vga_plot <= 1'b1;
            r_state    <= S_DRAW;
          end else begin
            r_state <= S_UPDATE;
          end
        end
        S_ERASE: begin
          if (vga_ready) begin
            if (r_need_draw) begin
              r_vga_x   <= r_cur_x;
              r_vga_y   <= r_cur_y;
              r_vga_col <= FG_COLOUR;
              r_state   <= S_DRAW;
            end else begin
              r_vga_plot <= 1'b0;
              r_state    <= S_UPDATE;
            end
          end
        end
        S_DRAW: begin
          if (vga_ready) begin
            r_vga_plot <= 1'b0;
            r_state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (r_slot_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_slot_idx <= r_slot_idx + 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign slot_idx   = r_slot_idx;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_col;
  assign vga_plot   = r_vga_plot;
  assign busy       = r_busy;
  assign sweep_done = r_done;
  assign overrun    = r_overrun;
endmodule

// File: doc/bullet_render_sweeper.md
Name: bullet_render_sweeper

Overview:
- Read side of the bullet pool: consumes per-slot bullet state (x, y, active) and turns it into single-pixel plot writes to the VGA adapter.
- On each frame tick it sweeps every slot once: erases the pixel it drew for that slot last sweep, then draws the slot's current position.
- Keeps its own shadow copy of the last drawn position per slot, so the pool never needs to report erase coordinates.

Parameters:
- NUM_SLOTS, 160, number of bullet slots swept (1..256).
- IDX_W, 8, slot index width; 2^IDX_W >= NUM_SLOTS.
- MAX_X, 159, largest drawable x.
- MAX_Y, 119, largest drawable y.
- FG_COLOUR, 3'b111, bullet colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse requesting a sweep.
- slot_idx  out  IDX_W  slot being read; registered.
- slot_x  in  8  x of slot_idx; valid one cycle after slot_idx changes.
- slot_y  in  7  y of slot_idx; same timing as slot_x.
- slot_active  in  1  slot is live (pool plot flag); same timing as slot_x.
- vga_x  out  8  plot x.
- vga_y  out  7  plot y.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  write request.
- vga_ready  in  1  adapter accepts the write this cycle; tie high for the plain adapter.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- overrun  out  1  sticky; set when a frame tick is dropped; cleared by reset.

Behaviour:
- Reset values (synchronous): all outputs 0, FSM IDLE, pending 0, every shadow valid bit 0.
- Shadow state per slot: prev_x[8], prev_y[7], prev_v[1].
- FSM states: IDLE, FETCH, LATCH, ERASE, DRAW, UPDATE, DONE.
  - IDLE: if frame_tick or pending, then slot_idx<=0, clear pending, busy<=1, go to FETCH.
  - FETCH: slot_idx is stable; wait one cycle for read latency.
  - LATCH: capture cur_x/cur_y/cur_a from the slot inputs. Define drawable = cur_a && cur_x<=MAX_X && cur_y<=MAX_Y. Define same = prev_v && drawable && prev_x==cur_x && prev_y==cur_y.
  - ERASE: entered if prev_v && !same, otherwise skipped. Drive vga_x/vga_y=prev, colour BG_COLOUR, vga_plot=1.
  - DRAW: entered if drawable && !same, otherwise skipped. Drive cur position, colour FG_COLOUR, vga_plot=1.
  - UPDATE: prev_x<=cur_x, prev_y<=cur_y, prev_v<=drawable. If slot_idx==NUM_SLOTS-1, go to DONE; else slot_idx+1 and go to FETCH.
  - DONE: sweep_done=1 for one cycle, busy<=0, go to IDLE.
- Write handshake:
  - vga_x/y/colour are held stable while vga_plot=1.
  - A write completes on the cycle vga_plot && vga_ready; the FSM advances on the next edge.
  - vga_plot drops to 0 outside ERASE/DRAW; there are no back-to-back writes without an intervening state change.
- Timing with vga_ready=1:
  - 5 cycles per moved slot, 4 with only erase or only draw, 3 for an idle or unmoved slot.
  - First slot_idx appears the cycle after frame_tick.
- Frame tick while busy: set pending, so a new sweep starts immediately after DONE. If pending is already set, set overrun; the extra tick is dropped.
- frame_tick in the same cycle as DONE counts as pending and is not lost.
- Out-of-range coordinates are never plotted; the shadow valid bit clears, so no later erase occurs.
- Reset mid-sweep:
  - Abort immediately: vga_plot 0 the next cycle, shadow cleared.
  - Pixels already on screen are not erased; the screen-clear owner handles that.
- slot_idx never exceeds NUM_SLOTS-1. There is no wrap within a sweep.

Decomposition:
- Shared package: SCREEN_MAX_X=159, SCREEN_MAX_Y=119, COORD_X_W=8, COORD_Y_W=7, COLOUR_W=3, FG/BG colour constants, and the FSM state encoding.
- One natural sub-module: bullet_shadow_ram. It is a NUM_SLOTS x 16-bit single-port array (x, y, valid) with combinational read and synchronous write, plus a synchronous clear-all on reset via the valid bits.

Test Plan:
- Reset, then a frame_tick with all slots inactive → busy high for NUM_SLOTS*3 cycles, zero vga_plot, one sweep_done.
- Slot 5 active at (40,30), one sweep → exactly one write: (40,30,3'b111).
  - Next sweep with slot 5 at (41,30) → erase (40,30,3'b000) then draw (41,30,3'b111), in that order.
- Slot 5 unchanged at (41,30) on a third sweep → no write for slot 5. Slot 5 goes inactive → single erase (41,30,3'b000).
- vga_ready held low 4 cycles during a draw → vga_x/y/colour/plot stable for all 4 cycles, and exactly one accepted write.
- Two extra frame_ticks mid-sweep → second sweep starts the cycle after sweep_done, overrun=1, and only two sweep_done pulses total.
- Slot 0 at (160,50) → no write. Reset asserted mid-sweep during a DRAW → vga_plot=0 the next cycle, busy=0, and the next sweep emits no erases.
